// File: rtl/audio_resampler_pkg.sv
// Shared types and constants for the PSG output resampler.
package audio_resampler_pkg;

  typedef logic signed [15:0] sample_t;

  localparam int NCO_W  = 24;
  localparam int FRAC_W = 16;
  localparam int CNT_W  = 9;

  localparam sample_t SAT_MAX = 16'sh7FFF;
  localparam sample_t SAT_MIN = 16'sh8000;

endpackage

// File: rtl/resample_nco.sv
// Phase-accumulator rate generator: one-clock tick on each wrap of a W-bit accumulator.
module resample_nco #(
  parameter int          W   = 24,
  parameter int unsigned INC = 14998
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  logic [W-1:0] r_acc;
  logic [W:0]   w_sum;

  assign w_sum = {1'b0, r_acc} + (W+1)'(INC);
  assign tick  = w_sum[W];

  always_ff @(posedge clk) begin
    if (reset) r_acc <= '0;
    else       r_acc <= w_sum[W-1:0];
  end

endmodule

// File: rtl/audio_resampler.sv
// Linear-interpolating resampler: input samples at ~300 kHz, output samples on NCO ticks,
// 3-clock MAC pipeline from tick to out_valid.
module audio_resampler
  import audio_resampler_pkg::*;
#(
  parameter int unsigned OUT_INC  = 14998,
  parameter int unsigned IN_RECIP = 366,
  parameter int unsigned UNDERRUN = 358
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    in_valid,
  input  sample_t data_in,
  output logic    out_valid,
  output sample_t data_out,
  output logic    underrun
);

  localparam logic [CNT_W-1:0]  PERIOD_LIM = CNT_W'(65536 / IN_RECIP);
  localparam logic [CNT_W-1:0]  UNDER_LIM  = CNT_W'(UNDERRUN - 1);
  localparam logic [FRAC_W-1:0] RECIP      = FRAC_W'(IN_RECIP);

  function automatic logic signed [17:0] round_q16(input logic signed [33:0] p);
    logic signed [33:0] t;
    t = p + 34'sd32768;
    return t[33:16];
  endfunction

  function automatic sample_t sat16(input logic signed [18:0] v);
    if (v > 19'(SAT_MAX)) return SAT_MAX;
    if (v < 19'(SAT_MIN)) return SAT_MIN;
    return v[15:0];
  endfunction

  logic w_tick;

  resample_nco #(.W(NCO_W), .INC(OUT_INC)) u_nco (
    .clk   (clk),
    .reset (reset),
    .tick  (w_tick)
  );

  sample_t          r_x0, r_x1;
  logic [CNT_W-1:0] r_cnt;
  logic             r_underrun;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_x0       <= '0;
      r_x1       <= '0;
      r_cnt      <= '0;
      r_underrun <= 1'b0;
    end else begin
      if (in_valid) begin
        r_x1  <= r_x0;
        r_x0  <= data_in;
        r_cnt <= '0;
      end else if (r_cnt != '1) begin
        r_cnt <= r_cnt + 1'b1;
      end
      // Sticky: set on the edge the counter reaches the starvation limit.
      if (!in_valid && r_cnt >= UNDER_LIM) r_underrun <= 1'b1;
    end
  end

  logic [CNT_W+FRAC_W-1:0] w_frac_full;
  logic [FRAC_W-1:0]       w_frac;
  logic signed [16:0]      w_diff;

  assign w_frac_full = (CNT_W+FRAC_W)'(r_cnt) * (CNT_W+FRAC_W)'(RECIP);
  assign w_frac      = (r_cnt >= PERIOD_LIM || |w_frac_full[CNT_W+FRAC_W-1:FRAC_W])
                       ? '1 : w_frac_full[FRAC_W-1:0];
  assign w_diff      = 17'(r_x0) - 17'(r_x1);

  sample_t            r_x1_p0, r_x1_p1, r_y_p2;
  logic [FRAC_W-1:0]  r_frac_p0;
  logic signed [16:0] r_diff_p0;
  logic signed [33:0] r_prod_p1;
  logic               r_vld_p0, r_vld_p1, r_vld_p2;
  logic signed [18:0] w_ysum;

  assign w_ysum = 19'(r_x1_p1) + 19'(round_q16(r_prod_p1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld_p0 <= 1'b0;
      r_vld_p1 <= 1'b0;
      r_vld_p2 <= 1'b0;
      r_y_p2   <= '0;
    end else begin
      r_vld_p0 <= w_tick;
      r_vld_p1 <= r_vld_p0;
      r_vld_p2 <= r_vld_p1;
      if (r_vld_p1) r_y_p2 <= sat16(w_ysum);
    end
  end

  always_ff @(posedge clk) begin
    // p0: snapshot history and fraction (pre-update values on an in_valid collision)
    r_x1_p0   <= r_x1;
    r_frac_p0 <= w_frac;
    r_diff_p0 <= w_diff;
    // p1: slope times fraction
    r_x1_p1   <= r_x1_p0;
    r_prod_p1 <= 34'(r_diff_p0) * 34'($signed({1'b0, r_frac_p0}));
  end

  assign out_valid = r_vld_p2;
  assign data_out  = r_y_p2;
  assign underrun  = r_underrun;

endmodule

// File: tb/tb_audio_resampler.sv
// Directed bench for audio_resampler: fast-tick instance for datapath checks, 2^20 instance for rate.
module tb_audio_resampler;
  import audio_resampler_pkg::*;

  logic    clk = 1'b0;
  logic    reset = 1'b1;
  logic    in_valid = 1'b0;
  sample_t data_in = '0;

  logic    out_valid, underrun;
  sample_t data_out;
  logic    r_out_valid, r_underrun;
  sample_t r_data_out;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  audio_resampler #(.OUT_INC(32'd8388608)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .data_in   (data_in),
    .out_valid (out_valid),
    .data_out  (data_out),
    .underrun  (underrun)
  );

  audio_resampler #(.OUT_INC(32'd1048576)) u_rate (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .data_in   (data_in),
    .out_valid (r_out_valid),
    .data_out  (r_data_out),
    .underrun  (r_underrun)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input sample_t v);
    in_valid = 1'b1;
    data_in  = v;
    step();
    in_valid = 1'b0;
  endtask

  // Leaves time just after the last reset edge; the next posedge is the first edge out of reset (E0).
  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    data_in  = '0;
    repeat (5) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    in_valid = 1'b1;
    data_in  = 16'sh7FFF;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0 || data_out !== 16'sd0 || underrun !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_hold[%0d]: out_valid=%b data_out=%0d underrun=%b, required 0/0/0",
                 i, out_valid, data_out, underrun);
      end
    end
    @(posedge clk);
    #1;
    reset    = 1'b0;
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (out_valid !== (k == 3)) begin
        n_fail++;
        $display("FAIL reset_release[%0d]: out_valid=%b required %b", k, out_valid, (k == 3));
      end
    end
    n_checks++;
    if (data_out !== 16'sd0) begin
      n_fail++;
      $display("FAIL reset_ignore_input: data_out=%0d required 0", data_out);
    end
  endtask

  task automatic test_dc();
    int seen = 0;
    do_reset();
    for (int p = 0; p < 20; p++) begin
      push(16'sh1000);
      for (int c = 0; c < 178; c++) begin
        @(negedge clk);
        if (p >= 1 && (p > 1 || c >= 4) && out_valid) begin
          seen++;
          n_checks++;
          if (data_out !== 16'sh1000) begin
            n_fail++;
            $display("FAIL dc[p%0d c%0d]: data_out=%h required 1000", p, c, data_out);
          end
        end
        step();
      end
    end
    n_checks++;
    if (seen < 1440) begin
      n_fail++;
      $display("FAIL dc_count: outputs seen=%0d required >= 1440", seen);
    end
  endtask

  task automatic test_midpoint();
    do_reset();
    step();
    push(16'sh4000);
    repeat (92) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1 || data_out !== 16'sd8144) begin
      n_fail++;
      $display("FAIL midpoint: out_valid=%b data_out=%0d required 1/8144", out_valid, data_out);
    end
  endtask

  task automatic test_extremes();
    do_reset();
    step();
    push(16'sd32767);
    push(-16'sd32768);
    repeat (181) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1 || data_out !== -16'sd32380) begin
      n_fail++;
      $display("FAIL extremes: out_valid=%b data_out=%0d required 1/-32380", out_valid, data_out);
    end
  endtask

  task automatic test_starvation();
    do_reset();
    step();
    push(16'sh2000);
    for (int k = 0; k < 363; k++) begin
      @(negedge clk);
      n_checks++;
      if (underrun !== (k >= 358)) begin
        n_fail++;
        $display("FAIL underrun_timing[%0d]: underrun=%b required %b", k, underrun, (k >= 358));
      end
      if (k >= 190 && out_valid) begin
        n_checks++;
        if (data_out !== 16'sh2000) begin
          n_fail++;
          $display("FAIL starve_clamp[%0d]: data_out=%h required 2000", k, data_out);
        end
      end
    end
    push(16'sh1234);
    push(16'sh1234);
    repeat (10) step();
    n_checks++;
    if (underrun !== 1'b1) begin
      n_fail++;
      $display("FAIL underrun_sticky: underrun=%b required 1", underrun);
    end
  endtask

  task automatic test_collision();
    do_reset();
    step();
    push(16'sh1000);
    step();
    push(16'sh3000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1 || data_out !== 16'sd23) begin
      n_fail++;
      $display("FAIL collision_old: out_valid=%b data_out=%0d required 1/23", out_valid, data_out);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1 || data_out !== 16'sd4142) begin
      n_fail++;
      $display("FAIL collision_next: out_valid=%b data_out=%0d required 1/4142", out_valid, data_out);
    end
  endtask

  task automatic test_rate();
    int cnt = 0;
    int bad_gap = 0;
    int last = -1;
    do_reset();
    repeat (32) @(posedge clk);
    for (int i = 0; i < 4096; i++) begin
      @(negedge clk);
      if (r_out_valid) begin
        if (last >= 0 && (i - last) != 16) bad_gap++;
        last = i;
        cnt++;
      end
    end
    n_checks++;
    if (cnt !== 256) begin
      n_fail++;
      $display("FAIL rate_count: out_valid count=%0d required 256", cnt);
    end
    n_checks++;
    if (bad_gap !== 0) begin
      n_fail++;
      $display("FAIL rate_spacing: irregular gaps=%0d required 0", bad_gap);
    end
  endtask

  initial begin
    test_reset();
    test_dc();
    test_midpoint();
    test_extremes();
    test_starvation();
    test_collision();
    test_rate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
